multimode_flipflop_bank: RTL and testbench
==========================================

MULTIMODE_FLIPFLOP_BANK -- requirements
Module: multimode_flipflop_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of independent flip-flop channels (1..32).
REQ-002 Parameter CNT_W, default 8, width of the transition counter (2..16).
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Reset_L  input  1  reset, asynchronous, active-low.
REQ-005 E  input  1  update enable; 0 = all channels hold.
REQ-006 MODE  input  2  requested mode: 00 SR, 01 JK, 10 D, 11 T.
REQ-007 A  input  WIDTH  per-channel primary input (S / J / D / T).
REQ-008 B  input  WIDTH  per-channel secondary input (R / K; ignored in D and T).
REQ-009 CLR_ERR  input  1  synchronous clear of ERR.
REQ-010 Q  output  WIDTH  flip-flop state.
REQ-011 Q_L  output  WIDTH  complement of Q.
REQ-012 ERR  output  WIDTH  sticky per-channel illegal-SR flag.
REQ-013 TOG_CNT  output  CNT_W  saturating count of Q bit transitions.
REQ-014 MODE_BUSY  output  1  high for the cycle after a mode switch.

Function
REQ-015 Block SHALL hold an active-mode register; at each edge where MODE differs from it, active mode SHALL load MODE, Q SHALL hold (no channel update at that edge, regardless of E), and MODE_BUSY SHALL be 1 for exactly the following cycle.
REQ-016 Mode tracking SHALL operate independently of E.
REQ-017 At an edge with E=1 and MODE equal to active mode, each channel i SHALL update per active mode; with E=0 all Q SHALL hold.
REQ-018 SR: A,B = 10 set, 01 reset, 00 hold, 11 hold and set ERR[i].
REQ-019 JK: 10 set, 01 reset, 00 hold, 11 toggle; ERR unaffected.
REQ-020 D: Q[i] <= A[i]; B ignored.
REQ-021 T: A[i]=1 toggles, A[i]=0 holds; B ignored.
REQ-022 Q_L SHALL equal ~Q combinationally at all times, including during reset.
REQ-023 ERR[i] SHALL stay set until an edge with CLR_ERR=1; if CLR_ERR and a new illegal SR on channel i coincide, ERR[i] SHALL be 1 (set wins).
REQ-024 Illegal-SR detection SHALL only occur on edges where a channel update is performed (E=1, no mode switch, SR mode).
REQ-025 At each update edge TOG_CNT SHALL increase by popcount(Q_next XOR Q), saturating at 2^CNT_W-1; no wrap-around.
REQ-026 Saturation SHALL be exact: if TOG_CNT + popcount exceeds max, result is max.
REQ-027 TOG_CNT SHALL be cleared only by reset.
REQ-028 All outputs except Q_L SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 Reset_L=0 SHALL immediately force Q=0, Q_L=all ones, ERR=0, TOG_CNT=0, MODE_BUSY=0, active mode=00 (SR), independent of Clk.
REQ-030 Reset asserted mid-operation (including during MODE_BUSY) SHALL abort the switch and apply REQ-029 values.
REQ-031 First rising edge after Reset_L rises SHALL be processed normally; MODE≠00 at that edge is a mode switch per REQ-015.

Verification
REQ-032 Reset, MODE=00, E=1, A=0001,B=0000 one edge -> Q=0001, Q_L=1110, TOG_CNT=1; then A=0000,B=0001 -> Q=0000, TOG_CNT=2.
REQ-033 SR, A=B=0011 with Q=0001 -> Q holds 0001, ERR=0011; next edge CLR_ERR=1 with A=B=0010 -> ERR=0010.
REQ-034 Change MODE 00->11 with A=1111, E=1 -> at switch edge Q holds, MODE_BUSY=1 next cycle; following edge Q toggles all bits, TOG_CNT += 4.
REQ-035 CNT_W=2, T mode, A=1111 repeatedly -> TOG_CNT 0->3 and stays 3.
REQ-036 JK, A=B=1111, E=0 for 3 edges -> Q unchanged; E=1 -> Q toggles each edge.
REQ-037 Reset_L pulsed low between edges during MODE_BUSY -> Q=0, Q_L=all ones, MODE_BUSY=0 immediately, active mode SR.

Source files
------------

// File: rtl/multimode_flipflop_bank.sv
// multimode_flipflop_bank
//
// Bank of WIDTH independent flip-flop channels sharing one operating mode
// (SR, JK, D or T). A registered copy of the requested mode is kept, and the
// edge on which that copy changes is a "switch" edge: no channel updates on
// it, and MODE_BUSY is high for the following cycle. Illegal SR inputs
// (S=R=1) set a sticky per-channel error flag. A saturating counter
// accumulates the number of Q bits that changed on each update edge.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset_L    in   asynchronous active-low reset
//   E          in   update enable (0 = all channels hold)
//   MODE[1:0]  in   requested mode: 00 SR, 01 JK, 10 D, 11 T
//   A[W-1:0]   in   per-channel S / J / D / T input
//   B[W-1:0]   in   per-channel R / K input (ignored in D and T)
//   CLR_ERR    in   synchronous clear of ERR (a coincident new error wins)
//   Q[W-1:0]   out  flip-flop state (registered)
//   Q_L[W-1:0] out  ~Q (combinational)
//   ERR[W-1:0] out  sticky illegal-SR flags (registered)
//   TOG_CNT    out  saturating count of Q bit transitions (registered)
//   MODE_BUSY  out  high for the cycle after a mode switch (registered)
module multimode_flipflop_bank #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset_L,
    input  logic             E,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_L,
    output logic [WIDTH-1:0] ERR,
    output logic [CNT_W-1:0] TOG_CNT,
    output logic             MODE_BUSY
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic             switch_w;
    logic             upd_w;
    logic [WIDTH-1:0] q_next_w;
    logic [WIDTH-1:0] illegal_w;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    // Sum is formed one bit wider than either operand so the overflow
    // compare is exact even when the popcount is wider than the counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return sum[CNT_W-1:0];
    endfunction

    always_comb begin
        mode_d    = mode_t'(MODE);
        switch_w  = (mode_t'(MODE) != mode_q);
        busy_d    = switch_w;
        upd_w     = E && !switch_w;
        q_next_w  = q_q;
        illegal_w = '0;

        case (mode_q)
            // S=R=0 and S=R=1 both hold; 10 sets, 01 resets.
            MODE_SR: begin
                q_next_w  = (q_q & ~(A ^ B)) | (A & ~B);
                illegal_w = A & B;
            end
            MODE_JK: q_next_w = (A & ~q_q) | (~B & q_q);
            MODE_D:  q_next_w = A;
            MODE_T:  q_next_w = q_q ^ A;
            default: q_next_w = q_q;
        endcase

        q_d   = upd_w ? q_next_w : q_q;
        cnt_d = upd_w ? sat_add(cnt_q, popcount(q_next_w ^ q_q)) : cnt_q;

        // Clear first, then OR in new errors so a coincident error wins.
        err_d = CLR_ERR ? '0 : err_q;
        if (upd_w) begin
            err_d = err_d | illegal_w;
        end
    end

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            mode_q <= MODE_SR;
            q_q    <= '0;
            err_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            q_q    <= q_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign Q         = q_q;
    assign Q_L       = ~q_q;
    assign ERR       = err_q;
    assign TOG_CNT   = cnt_q;
    assign MODE_BUSY = busy_q;

endmodule

// File: tb/tb_multimode_flipflop_bank.sv
module tb_multimode_flipflop_bank;

    logic       Clk = 1'b0;
    logic       Reset_L;
    logic       E;
    logic [1:0] MODE;
    logic [3:0] A, B;
    logic       CLR_ERR;
    logic [3:0] Q, Q_L, ERR;
    logic [7:0] TOG_CNT;
    logic       MODE_BUSY;
    logic [3:0] Q2, Q_L2, ERR2;
    logic [1:0] TOG_CNT2;
    logic       MODE_BUSY2;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    multimode_flipflop_bank #(.WIDTH(4), .CNT_W(8)) dut (
        .Clk(Clk), .Reset_L(Reset_L), .E(E), .MODE(MODE), .A(A), .B(B),
        .CLR_ERR(CLR_ERR), .Q(Q), .Q_L(Q_L), .ERR(ERR), .TOG_CNT(TOG_CNT),
        .MODE_BUSY(MODE_BUSY)
    );

    multimode_flipflop_bank #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset_L(Reset_L), .E(E), .MODE(MODE), .A(A), .B(B),
        .CLR_ERR(CLR_ERR), .Q(Q2), .Q_L(Q_L2), .ERR(ERR2), .TOG_CNT(TOG_CNT2),
        .MODE_BUSY(MODE_BUSY2)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_L = 1'b0; E = 1'b0; MODE = 2'b00; A = 4'h0; B = 4'h0; CLR_ERR = 1'b0;
        #12;
        checks++; if (Q !== 4'h0) begin errors++; $display("FAIL reset_q got %h want 0", Q); end
        checks++; if (Q_L !== 4'hF) begin errors++; $display("FAIL reset_ql got %h want f", Q_L); end
        checks++; if (ERR !== 4'h0) begin errors++; $display("FAIL reset_err got %h want 0", ERR); end
        checks++; if (TOG_CNT !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", TOG_CNT); end
        checks++; if (MODE_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", MODE_BUSY); end
        Reset_L = 1'b1;
    endtask

    task automatic test_sr();
        E = 1'b1; MODE = 2'b00; A = 4'b0001; B = 4'b0000;
        step();
        checks++; if (Q !== 4'b0001) begin errors++; $display("FAIL sr_set_q got %b want 0001", Q); end
        checks++; if (Q_L !== 4'b1110) begin errors++; $display("FAIL sr_set_ql got %b want 1110", Q_L); end
        checks++; if (TOG_CNT !== 8'd1) begin errors++; $display("FAIL sr_set_cnt got %0d want 1", TOG_CNT); end
        checks++; if (MODE_BUSY !== 1'b0) begin errors++; $display("FAIL sr_nobusy got %b want 0", MODE_BUSY); end
        A = 4'b0000; B = 4'b0001;
        step();
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL sr_reset_q got %b want 0000", Q); end
        checks++; if (TOG_CNT !== 8'd2) begin errors++; $display("FAIL sr_reset_cnt got %0d want 2", TOG_CNT); end
        A = 4'b0001; B = 4'b0000;
        step();
        A = 4'b0011; B = 4'b0011;
        step();
        checks++; if (Q !== 4'b0001) begin errors++; $display("FAIL sr_illegal_q got %b want 0001", Q); end
        checks++; if (ERR !== 4'b0011) begin errors++; $display("FAIL sr_illegal_err got %b want 0011", ERR); end
        checks++; if (TOG_CNT !== 8'd3) begin errors++; $display("FAIL sr_illegal_cnt got %0d want 3", TOG_CNT); end
        CLR_ERR = 1'b1; A = 4'b0010; B = 4'b0010;
        step();
        checks++; if (ERR !== 4'b0010) begin errors++; $display("FAIL sr_clr_setwins got %b want 0010", ERR); end
        // Illegal SR with E=0 must not flag anything.
        CLR_ERR = 1'b1; E = 1'b0; A = 4'b0000; B = 4'b0000;
        step();
        checks++; if (ERR !== 4'b0000) begin errors++; $display("FAIL sr_clr got %b want 0000", ERR); end
        CLR_ERR = 1'b0; A = 4'b1111; B = 4'b1111;
        step();
        checks++; if (ERR !== 4'b0000) begin errors++; $display("FAIL sr_e0_noerr got %b want 0000", ERR); end
        checks++; if (Q !== 4'b0001) begin errors++; $display("FAIL sr_e0_hold got %b want 0001", Q); end
    endtask

    task automatic test_mode_switch();
        E = 1'b1; MODE = 2'b11; A = 4'b1111; B = 4'b0000;
        step();
        checks++; if (Q !== 4'b0001) begin errors++; $display("FAIL sw_hold_q got %b want 0001", Q); end
        checks++; if (MODE_BUSY !== 1'b1) begin errors++; $display("FAIL sw_busy got %b want 1", MODE_BUSY); end
        checks++; if (TOG_CNT !== 8'd3) begin errors++; $display("FAIL sw_cnt got %0d want 3", TOG_CNT); end
        step();
        checks++; if (Q !== 4'b1110) begin errors++; $display("FAIL t_toggle_q got %b want 1110", Q); end
        checks++; if (TOG_CNT !== 8'd7) begin errors++; $display("FAIL t_toggle_cnt got %0d want 7", TOG_CNT); end
        checks++; if (MODE_BUSY !== 1'b0) begin errors++; $display("FAIL sw_busy_drop got %b want 0", MODE_BUSY); end
    endtask

    task automatic test_jk();
        // Mode switch happens with E=0 as well.
        E = 1'b0; MODE = 2'b01; A = 4'b1111; B = 4'b1111;
        step();
        checks++; if (MODE_BUSY !== 1'b1) begin errors++; $display("FAIL jk_busy_e0 got %b want 1", MODE_BUSY); end
        step();
        step();
        checks++; if (Q !== 4'b1110) begin errors++; $display("FAIL jk_e0_hold got %b want 1110", Q); end
        checks++; if (TOG_CNT !== 8'd7) begin errors++; $display("FAIL jk_e0_cnt got %0d want 7", TOG_CNT); end
        E = 1'b1;
        step();
        checks++; if (Q !== 4'b0001) begin errors++; $display("FAIL jk_tog1 got %b want 0001", Q); end
        step();
        checks++; if (Q !== 4'b1110) begin errors++; $display("FAIL jk_tog2 got %b want 1110", Q); end
        checks++; if (TOG_CNT !== 8'd15) begin errors++; $display("FAIL jk_tog_cnt got %0d want 15", TOG_CNT); end
        A = 4'b0101; B = 4'b1010;
        step();
        checks++; if (Q !== 4'b0101) begin errors++; $display("FAIL jk_setreset got %b want 0101", Q); end
        checks++; if (TOG_CNT !== 8'd18) begin errors++; $display("FAIL jk_sr_cnt got %0d want 18", TOG_CNT); end
        checks++; if (ERR !== 4'b0000) begin errors++; $display("FAIL jk_noerr got %b want 0000", ERR); end
    endtask

    task automatic test_d();
        MODE = 2'b10; A = 4'b0011; B = 4'b1111; E = 1'b1;
        step();
        checks++; if (Q !== 4'b0101) begin errors++; $display("FAIL d_switch_hold got %b want 0101", Q); end
        step();
        checks++; if (Q !== 4'b0011) begin errors++; $display("FAIL d_load got %b want 0011", Q); end
        checks++; if (TOG_CNT !== 8'd20) begin errors++; $display("FAIL d_cnt got %0d want 20", TOG_CNT); end
    endtask

    task automatic test_reset_during_busy();
        MODE = 2'b11; A = 4'b1111; E = 1'b1;
        step();
        checks++; if (MODE_BUSY !== 1'b1) begin errors++; $display("FAIL rb_pre_busy got %b want 1", MODE_BUSY); end
        #2 Reset_L = 1'b0;
        #1;
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL rb_q got %b want 0000", Q); end
        checks++; if (Q_L !== 4'b1111) begin errors++; $display("FAIL rb_ql got %b want 1111", Q_L); end
        checks++; if (MODE_BUSY !== 1'b0) begin errors++; $display("FAIL rb_busy got %b want 0", MODE_BUSY); end
        checks++; if (TOG_CNT !== 8'd0) begin errors++; $display("FAIL rb_cnt got %0d want 0", TOG_CNT); end
        #1 Reset_L = 1'b1;
        // Active mode is SR again, so MODE=11 is a switch: hold, then toggle.
        step();
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL rb_first_hold got %b want 0000", Q); end
        checks++; if (MODE_BUSY !== 1'b1) begin errors++; $display("FAIL rb_first_busy got %b want 1", MODE_BUSY); end
        step();
        checks++; if (Q !== 4'b1111) begin errors++; $display("FAIL rb_t_toggle got %b want 1111", Q); end
    endtask

    task automatic test_saturation();
        Reset_L = 1'b0; E = 1'b1; MODE = 2'b11; A = 4'b0001; B = 4'b0000;
        #3 Reset_L = 1'b1;
        step();
        checks++; if (TOG_CNT2 !== 2'd0) begin errors++; $display("FAIL sat_switch got %0d want 0", TOG_CNT2); end
        step();
        checks++; if (TOG_CNT2 !== 2'd1) begin errors++; $display("FAIL sat_c1 got %0d want 1", TOG_CNT2); end
        step();
        step();
        checks++; if (TOG_CNT2 !== 2'd3) begin errors++; $display("FAIL sat_c3 got %0d want 3", TOG_CNT2); end
        step();
        checks++; if (TOG_CNT2 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d want 3", TOG_CNT2); end
        A = 4'b1111;
        step();
        step();
        checks++; if (TOG_CNT2 !== 2'd3) begin errors++; $display("FAIL sat_big got %0d want 3", TOG_CNT2); end
        checks++; if (TOG_CNT !== 8'd12) begin errors++; $display("FAIL sat_wide_cnt got %0d want 12", TOG_CNT); end
    endtask

    initial begin
        test_reset();
        test_sr();
        test_mode_switch();
        test_jk();
        test_d();
        test_reset_during_busy();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
